// File: rtl/cordic_mac_ctrl.sv
// Sequencer and saturating accumulator for the 8-bit CORDIC linear-mode multiplier.
// Walks the multiplier through load plus seven iterations per (a, b) pair and sums the products.
module cordic_mac_ctrl #(
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic [7:0]       mul_a,
  output logic [7:0]       mul_b,
  output logic [2:0]       mul_counter,
  output logic             mul_start,
  output logic             mul_stop,
  input  logic [15:0]      mul_c,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_count,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {IDLE, LOAD, ITER, OUT} state_t;

  state_t                  state, state_nxt;
  logic [2:0]              step, step_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic [7:0]              cnt, cnt_nxt;
  logic                    ovf, ovf_nxt;
  logic                    last_q;
  logic signed [ACC_W-1:0] sat_sum;
  logic                    sat_ovf;

  // Returns {clamped, sum}; one guard bit is enough because the product is only 16 bits wide.
  function automatic logic [ACC_W:0] sat_add(input logic signed [ACC_W-1:0] a,
                                             input logic signed [15:0] p);
    logic signed [ACC_W:0] pe;
    logic signed [ACC_W:0] s;
    pe = {{(ACC_W-15){p[15]}}, p};
    s  = $signed({a[ACC_W-1], a}) + pe;
    if (s[ACC_W] != s[ACC_W-1])
      return {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
    return {1'b0, s[ACC_W-1:0]};
  endfunction

  assign {sat_ovf, sat_sum} = sat_add(acc, $signed(mul_c));

  assign in_ready    = (state == IDLE) && !rst;
  assign mul_counter = step;
  assign mul_start   = (state == LOAD);
  assign mul_stop    = (state == IDLE) || (state == OUT);
  assign out_valid   = (state == OUT);
  assign out_sum     = acc;
  assign out_count   = cnt;
  assign out_ovf     = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      step   <= 3'd0;
      acc    <= '0;
      cnt    <= 8'd0;
      ovf    <= 1'b0;
      mul_a  <= 8'd0;
      mul_b  <= 8'd0;
      last_q <= 1'b0;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      if (in_valid && in_ready) begin
        mul_a  <= in_a;
        mul_b  <= in_b;
        last_q <= in_last;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    case (state)
      IDLE: if (in_valid) state_nxt = LOAD;
      LOAD: begin
        state_nxt = ITER;
        step_nxt  = 3'd1;
      end
      ITER: begin
        if (step == 3'd7) begin
          // Product is final only in the last iteration; step returns to 0 so the counter idles at load.
          acc_nxt   = sat_sum;
          ovf_nxt   = ovf | sat_ovf;
          cnt_nxt   = (cnt == 8'd255) ? cnt : cnt + 8'd1;
          step_nxt  = 3'd0;
          state_nxt = last_q ? OUT : IDLE;
        end else begin
          step_nxt = step + 3'd1;
        end
      end
      OUT: begin
        if (out_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = 8'd0;
          ovf_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cordic_mac_ctrl.sv
// Bench for cordic_mac_ctrl: two instances (ACC_W=20 and ACC_W=16) share stimulus, each driving a
// behavioural multiplier that only yields the product when walked through load and steps 1..7 in order.
module tb_cordic_mac_ctrl;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_a = 8'd0, in_b = 8'd0;

  logic        in_ready[2];
  logic [7:0]  mul_a[2], mul_b[2];
  logic [2:0]  mul_counter[2];
  logic        mul_start[2], mul_stop[2];
  logic [15:0] mul_c[2];
  logic [19:0] out_sum20;
  logic [15:0] out_sum16;
  logic [7:0]  out_count[2];
  logic        out_ovf[2], out_valid[2];

  int checks = 0, errors = 0, cyc = 0;
  int qa[$], qb[$];
  logic [127:0] act, exp;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cordic_mac_ctrl #(.ACC_W(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(mul_a[0]), .mul_b(mul_b[0]), .mul_counter(mul_counter[0]),
    .mul_start(mul_start[0]), .mul_stop(mul_stop[0]), .mul_c(mul_c[0]), .out_sum(out_sum20),
    .out_count(out_count[0]), .out_ovf(out_ovf[0]), .out_valid(out_valid[0]), .out_ready(out_ready));

  cordic_mac_ctrl #(.ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .mul_a(mul_a[1]), .mul_b(mul_b[1]), .mul_counter(mul_counter[1]),
    .mul_start(mul_start[1]), .mul_stop(mul_stop[1]), .mul_c(mul_c[1]), .out_sum(out_sum16),
    .out_count(out_count[1]), .out_ovf(out_ovf[1]), .out_valid(out_valid[1]), .out_ready(out_ready));

  // Multiplier stand-in: any out-of-order step poisons it; output is garbage except at a proper step 7.
  logic signed [7:0] ma[2], mb[2];
  logic [3:0] mstep[2];

  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (!mul_stop[i]) begin
        if (mul_start[i] && mul_counter[i] == 3'd0) begin
          ma[i] <= mul_a[i];
          mb[i] <= mul_b[i];
          mstep[i] <= 4'd0;
        end else if ({1'b0, mul_counter[i]} == mstep[i] + 4'd1) mstep[i] <= mstep[i] + 4'd1;
        else mstep[i] <= 4'd15;
      end

  always_comb begin
    int p;
    p = 0;
    for (int i = 0; i < 2; i++) begin
      mul_c[i] = 16'hA5A5;
      if (!mul_stop[i] && mul_counter[i] == 3'd7 && mstep[i] == 4'd6) begin
        p = int'(ma[i]) * int'(mb[i]);
        mul_c[i] = p[15:0];
      end
    end
  end

  // Reference: products summed with clamp after every addition, count saturating at 255.
  function automatic void ref_vec(input int w, output longint sum, output int cnt, output bit ovf);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    sum = 0; cnt = 0; ovf = 0;
    foreach (qa[k]) begin
      sum += longint'(qa[k] * qb[k]);
      if (sum > mx) begin sum = mx; ovf = 1; end
      else if (sum < mn) begin sum = mn; ovf = 1; end
      if (cnt < 255) cnt++;
    end
  endfunction

  function automatic int rnd8();
    int r;
    r = int'($urandom_range(0, 255));
    if ($urandom_range(0, 3) == 0) r = ($urandom_range(0, 1) == 1) ? 127 : 128;
    return (r > 127) ? r - 256 : r;
  endfunction

  // Called right after a negedge; returns right after the negedge following the accepting edge.
  task automatic send_pair(input logic [7:0] a, input logic [7:0] b, input logic last, input bit hold,
                           output int acc_cyc, output bit ok);
    int n = 0;
    ok = 0; acc_cyc = -1;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    while (!in_ready[0] && n < 40) begin @(negedge clk); n++; end
    if (in_ready[0]) begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      ok = 1;
    end
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_out(output bit ok);
    int n = 0;
    while (!out_valid[0] && n < 300) begin @(negedge clk); n++; end
    ok = out_valid[0];
  endtask

  task automatic run_vec(input bit gaps, output bit ok);
    int ac;
    bit sok;
    ok = 1;
    for (int k = 0; k < qa.size(); k++) begin
      if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      send_pair(8'(qa[k]), 8'(qb[k]), k == qa.size() - 1, 0, ac, sok);
      if (!sok) ok = 0;
    end
    wait_out(sok);
    if (!sok) ok = 0;
  endtask

  task automatic pop(input int delay);
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    act = {in_ready[0], in_ready[1], mul_stop[0], mul_stop[1], mul_start[0], mul_start[1], mul_counter[0],
           out_valid[0], out_valid[1], out_sum20, out_sum16, out_count[0], out_ovf[0], mul_a[0], mul_b[0]};
    exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 20'd0, 16'd0, 8'd0, 1'b0, 8'd0, 8'd0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL reset_values: got %h want %h", act, exp); end
    rst = 1'b0;
    @(negedge clk);
    act = {in_ready[0], in_ready[1], mul_stop[0], out_valid[0]};
    exp = {1'b1, 1'b1, 1'b1, 1'b0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL reset_release: got %h want %h", act, exp); end
  endtask

  task automatic test_single;
    int ac;
    bit ok;
    send_pair(8'd5, 8'd3, 1'b1, 0, ac, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: got no accept want accept"); end
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) @(negedge clk);
      act = {mul_counter[0], mul_start[0], mul_stop[0], out_valid[0], in_ready[0], mul_counter[1], out_valid[1]};
      if (k == 1) exp = {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
      else if (k < 9) exp = {3'(k - 1), 1'b0, 1'b0, 1'b0, 1'b0, 3'(k - 1), 1'b0};
      else exp = {3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL single_seq_cycle%0d: got %h want %h", k, act, exp); end
    end
    act = {out_sum20, out_sum16, out_count[0], out_count[1], out_ovf[0], out_ovf[1], mul_a[0], mul_b[0]};
    exp = {20'd15, 16'd15, 8'd1, 8'd1, 2'b00, 8'd5, 8'd3};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL single_result: got %h want %h", act, exp); end
    pop(0);
    act = {out_valid[0], out_valid[1], in_ready[0], out_sum20, out_count[0]};
    exp = {1'b0, 1'b0, 1'b1, 20'd0, 8'd0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL single_release: got %h want %h", act, exp); end
  endtask

  task automatic test_back_to_back;
    int a[4] = '{2, -4, 7, -1};
    int b[4] = '{3, 5, -2, -6};
    int ac[4];
    bit ok;
    for (int k = 0; k < 4; k++) begin
      send_pair(8'(a[k]), 8'(b[k]), k == 3, k < 3, ac[k], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_accept%0d: got no accept want accept", k); end
      else if (k > 0) begin
        checks++;
        if (ac[k] - ac[k-1] !== 9) begin
          errors++; $display("FAIL b2b_interval%0d: got %0d want 9", k, ac[k] - ac[k-1]);
        end
      end
    end
    wait_out(ok);
    act = {ok, out_sum20, out_sum16, out_count[0], out_count[1], out_ovf[0], out_ovf[1]};
    exp = {1'b1, 20'(-22), 16'(-22), 8'd4, 8'd4, 2'b00};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL b2b_result: got %h want %h", act, exp); end
    pop(1);
  endtask

  task automatic test_backpressure;
    bit ok;
    longint e20, e16;
    int ec, ec16;
    bit eo20, eo16;
    logic [19:0] snap_sum;
    logic [7:0] snap_a;
    qa.delete(); qb.delete();
    for (int k = 0; k < 3; k++) begin qa.push_back(rnd8()); qb.push_back(rnd8()); end
    run_vec(1, ok);
    ref_vec(20, e20, ec, eo20); ref_vec(16, e16, ec16, eo16);
    act = {ok, out_sum20, out_sum16, out_count[0], out_count[1], out_ovf[0], out_ovf[1]};
    exp = {1'b1, 20'(e20), 16'(e16), 8'(ec), 8'(ec16), eo20, eo16};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL bp_result: got %h want %h", act, exp); end
    snap_sum = out_sum20; snap_a = mul_a[0];
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_last = 1'b1;
      @(negedge clk);
      act = {out_valid[0], in_ready[0], in_ready[1], out_sum20, out_count[0], mul_a[0]};
      exp = {1'b1, 1'b0, 1'b0, snap_sum, 8'(ec), snap_a};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL bp_hold%0d: got %h want %h", k, act, exp); end
    end
    in_valid = 1'b0;
    pop(0);
    act = {out_valid[0], out_valid[1], out_sum20, out_count[0]};
    exp = {1'b0, 1'b0, 20'd0, 8'd0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL bp_release: got %h want %h", act, exp); end
    qa.delete(); qb.delete();
    qa.push_back(rnd8()); qb.push_back(rnd8());
    run_vec(0, ok);
    ref_vec(20, e20, ec, eo20); ref_vec(16, e16, ec16, eo16);
    act = {ok, out_sum20, out_sum16, out_count[0], out_ovf[0], out_ovf[1]};
    exp = {1'b1, 20'(e20), 16'(e16), 8'(ec), eo20, eo16};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL bp_next_vector: got %h want %h", act, exp); end
    pop(0);
  endtask

  task automatic test_saturation;
    bit ok;
    longint e20, e16;
    int ec, ec16;
    bit eo20, eo16;
    for (int c = 0; c < 4; c++) begin
      qa.delete(); qb.delete();
      case (c)
        0: repeat (200) begin qa.push_back(127); qb.push_back(127); end
        1: repeat (300) begin qa.push_back(127); qb.push_back(127); end
        2: begin
          repeat (3) begin qa.push_back(127); qb.push_back(127); end
          qa.push_back(-128); qb.push_back(127);
        end
        default: repeat (3) begin qa.push_back(-128); qb.push_back(127); end
      endcase
      run_vec(0, ok);
      ref_vec(20, e20, ec, eo20); ref_vec(16, e16, ec16, eo16);
      act = {ok, out_sum20, out_sum16, out_count[0], out_count[1], out_ovf[0], out_ovf[1]};
      exp = {1'b1, 20'(e20), 16'(e16), 8'(ec), 8'(ec16), eo20, eo16};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL sat_case%0d: got %h want %h", c, act, exp); end
      pop(0);
    end
  endtask

  task automatic test_reset_abort;
    int ac, n;
    bit ok;
    send_pair(8'd1, 8'd1, 1'b0, 0, ac, ok);
    send_pair(8'd1, 8'd1, 1'b0, 0, ac, ok);
    n = 0;
    while (mul_counter[0] !== 3'd4 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (mul_counter[0] !== 3'd4) begin errors++; $display("FAIL abort_reach_step4: got %0d want 4", mul_counter[0]); end
    rst = 1'b1;
    @(negedge clk);
    act = {in_ready[0], mul_stop[0], mul_stop[1], mul_start[0], mul_counter[0], mul_counter[1], out_valid[0],
           out_sum20, out_sum16, out_count[0], out_count[1], out_ovf[0], mul_a[0], mul_b[0]};
    exp = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 20'd0, 16'd0, 8'd0, 8'd0, 1'b0, 8'd0, 8'd0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL abort_reset_values: got %h want %h", act, exp); end
    rst = 1'b0;
    @(negedge clk);
    qa = '{1, 1, 1}; qb = '{1, 1, 1};
    run_vec(0, ok);
    act = {ok, out_sum20, out_sum16, out_count[0], out_ovf[0]};
    exp = {1'b1, 20'd3, 16'd3, 8'd3, 1'b0};
    checks++;
    if (act !== exp) begin errors++; $display("FAIL abort_rerun: got %h want %h", act, exp); end
    pop(0);
  endtask

  task automatic test_negative;
    int a[3] = '{-8, -8, 8};
    int b[3] = '{-8, 8, -8};
    int r[3] = '{64, -64, -64};
    bit ok;
    for (int k = 0; k < 3; k++) begin
      qa.delete(); qb.delete();
      qa.push_back(a[k]); qb.push_back(b[k]);
      run_vec(0, ok);
      act = {ok, out_sum20, out_sum16, out_count[0], out_ovf[0]};
      exp = {1'b1, 20'(r[k]), 16'(r[k]), 8'd1, 1'b0};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL neg_case%0d: got %h want %h", k, act, exp); end
      pop(0);
    end
  endtask

  task automatic test_random;
    bit ok;
    longint e20, e16;
    int ec, ec16;
    bit eo20, eo16;
    for (int v = 0; v < 12; v++) begin
      qa.delete(); qb.delete();
      repeat ($urandom_range(1, 6)) begin qa.push_back(rnd8()); qb.push_back(rnd8()); end
      run_vec(1, ok);
      ref_vec(20, e20, ec, eo20); ref_vec(16, e16, ec16, eo16);
      act = {ok, out_sum20, out_sum16, out_count[0], out_count[1], out_ovf[0], out_ovf[1]};
      exp = {1'b1, 20'(e20), 16'(e16), 8'(ec), 8'(ec16), eo20, eo16};
      checks++;
      if (act !== exp) begin errors++; $display("FAIL random_vec%0d: got %h want %h", v, act, exp); end
      pop($urandom_range(0, 4));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_backpressure;
    test_saturation;
    test_reset_abort;
    test_negative;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
